// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin arbiter: N valid/ready beat streams share one
// registered 8-bit output stream; a granted packet owns it until its last beat.
module stream_rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [8*N-1:0] in_data,
  input  logic [N-1:0]   in_last,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [7:0]     o_data,
  output logic           o_last,
  output logic [IDW-1:0] o_src,
  output logic           busy
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic           o_valid_q, o_valid_d;
  logic [7:0]     o_data_q, o_data_d;
  logic           o_last_q, o_last_d;
  logic [IDW-1:0] o_src_q, o_src_d;

  logic [2*N-1:0] dbl;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] grant;
  logic [7:0]     beat_data;
  logic           beat_last;
  logic           beat_valid;
  logic           slot_free;
  logic           offer;
  logic           xfer;

  function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] v);
    logic [IDW-1:0] r;
    if (int'(v) >= N - 1) r = '0;
    else r = v + 1'b1;
    return r;
  endfunction

  // Rotate so bit k is requester (rr_ptr+k) mod N; lowest k wins.
  always_comb begin
    int s;
    s = 0;
    winner = rr_ptr_q;
    dbl = {in_valid, in_valid} >> rr_ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        s = int'(rr_ptr_q) + k;
        if (s >= N) s = s - N;
        winner = s[IDW-1:0];
      end
    end
  end

  always_comb begin
    grant = (state_q == IDLE) ? winner : lock_id_q;
    beat_data = '0;
    beat_last = 1'b0;
    beat_valid = 1'b0;
    for (int g = 0; g < N; g++) begin
      if (grant == IDW'(g)) begin
        beat_data = in_data[8*g +: 8];
        beat_last = in_last[g];
        beat_valid = in_valid[g];
      end
    end
    slot_free = !o_valid_q || o_ready;
    // A locked owner sees ready even across gaps in its packet.
    offer = reset && slot_free &&
            (beat_valid || state_q == LOCKED);
    in_ready = '0;
    for (int g = 0; g < N; g++) begin
      in_ready[g] = offer && (grant == IDW'(g));
    end
    xfer = offer && beat_valid;
  end

  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    lock_id_d = lock_id_q;
    o_valid_d = o_valid_q;
    o_data_d = o_data_q;
    o_last_d = o_last_q;
    o_src_d = o_src_q;
    if (xfer) begin
      o_valid_d = 1'b1;
      o_data_d = beat_data;
      o_last_d = beat_last;
      o_src_d = grant;
    end else if (o_ready) begin
      o_valid_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (beat_last) begin
            rr_ptr_d = inc_mod(grant);
          end else begin
            state_d = LOCKED;
            lock_id_d = grant;
          end
        end
      end
      LOCKED: begin
        if (xfer && beat_last) begin
          state_d = IDLE;
          rr_ptr_d = inc_mod(lock_id_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      lock_id_q <= '0;
      o_valid_q <= 1'b0;
      o_data_q <= '0;
      o_last_q <= 1'b0;
      o_src_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      lock_id_q <= lock_id_d;
      o_valid_q <= o_valid_d;
      o_data_q <= o_data_d;
      o_last_q <= o_last_d;
      o_src_q <= o_src_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data = o_data_q;
  assign o_last = o_last_q;
  assign o_src = o_src_q;
  assign busy = (state_q == LOCKED);

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Packet-aware round-robin arbiter that shares the single 8-bit valid/ready output stream of the test top between N requester streams.
- Once a requester wins, it holds the output until its last beat is accepted, so packets never interleave.
- The output stage is one registered beat, giving one cycle of latency at full throughput.
- It sits in front of the top's input stream; its output o_* drives i_valid/i_data and consumes i_ready.

Parameters:
- N, 4, number of requesters; legal range 2..8.
- IDW, $clog2(N), width of the source-id field. Derived, not overridable.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately; release is synchronous to clock.
- in_valid  input  N  per-requester beat valid.
- in_ready  output  N  per-requester beat accepted; one-hot or zero.
- in_data  input  8*N  requester i occupies bits [8i+7:8i].
- in_last  input  N  marks the final beat of a packet.
- o_valid  output  1  registered output beat valid.
- o_ready  input  1  downstream accept.
- o_data  output  8  registered beat data.
- o_last  output  1  registered last flag.
- o_src  output  IDW  index of the requester that produced the current o_* beat.
- busy  output  1  1 while in LOCKED state.

Behaviour:
- Reset values: o_valid=0, o_data=0, o_last=0, o_src=0, busy=0, state=IDLE, rr_ptr=0, lock_id=0. in_ready=0 while reset is low.
- slot_free = !o_valid || o_ready. A beat transfers from requester g when in_valid[g] && in_ready[g].
- Winner (IDLE only):
  - The first requester with in_valid set, scanning rr_ptr, rr_ptr+1, ... modulo N.
  - Combinational, so there is no arbitration bubble.
- grant = (state==IDLE) ? winner : lock_id.
- in_ready[g] = slot_free && in_valid[grant] && (g==grant). All other bits are 0.
  - Exception: in LOCKED state, in_ready[lock_id] = slot_free regardless of in_valid.
- On transfer, the next cycle has o_valid=1, o_data=in_data[grant], o_last=in_last[grant], o_src=grant. Latency is exactly 1 cycle.
- If o_valid && o_ready and no new transfer occurs, o_valid drops to 0.
- While o_valid && !o_ready, o_data, o_last and o_src are held stable. No input is accepted during this time.
- State machine:
  - IDLE, transfer with in_last=0 -> LOCKED. lock_id=grant.
  - IDLE, transfer with in_last=1 -> IDLE (single-beat packet). rr_ptr=grant+1 mod N.
  - LOCKED, transfer with in_last=1 -> IDLE. rr_ptr=lock_id+1 mod N.
  - LOCKED, otherwise -> LOCKED. Other requesters' in_valid is ignored even if lock_id deasserts in_valid (gap inside a packet).
- rr_ptr advances only on packet completion. A winner that has not yet transferred (because slot_free=0) can be displaced by a higher-priority requester that becomes valid later. This is legal because no beat has moved yet.
- Fairness: with all N requesters continuously valid and single-beat packets, grants cycle 0,1,..,N-1,0.
- Wrap: rr_ptr = N-1 followed by a completion of N-1 gives rr_ptr = 0. Arithmetic is modulo N, including non-power-of-2 N.
- Simultaneous events: a downstream pop (o_ready) and a new accept in the same cycle are both honoured. o_valid stays 1 and takes the new beat.
- Reset mid-packet: all state clears asynchronously and the partial packet is abandoned. After release, arbitration restarts from rr_ptr=0.
- busy mirrors state==LOCKED, registered.

Test Plan:
- Reset, then req0 sends 3 beats 0x11,0x22,0x33 (last on 0x33) with o_ready=1 -> o_data 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after the first accept; o_src=0; o_last only on 0x33; busy=1 for 2 cycles.
- req1 and req2 both valid with single-beat packets 0xA1, 0xB2 after reset (rr_ptr=0) -> req1 is served first, then req2; o_src 1 then 2; never two in_ready bits set together.
- req0 mid-packet (beat 2 of 4) while req3 raises valid -> req3 in_ready stays 0 until req0's last beat transfers; req3's beat appears the cycle after req0's last beat on o_data.
- o_ready=0 for 5 cycles with o_valid=1, o_data=0x5A -> o_data, o_last and o_src stay constant and all in_ready=0; o_ready=1 -> 0x5A is consumed and the next beat follows with no bubble.
- All 4 requesters continuously valid with single-beat packets for 12 beats -> o_src sequence 0,1,2,3,0,1,2,3,0,1,2,3; throughput 1 beat/cycle.
- reset asserted low during LOCKED (req2, beat 2 of 3) -> o_valid=0, busy=0 and in_ready=0 immediately without waiting for a clock edge; after release with req2 and req0 valid -> req0 is granted first.
